// File: rtl/fsm_seq_if.sv
// Handshake and status bundle between the sequencer and its surroundings.
// The slave side is the sequencer; the master side drives run/instr/ready.
interface fsm_seq_if #(
    parameter int STG_W = 3
);
    logic             run;
    logic             memctrl_ready;
    logic [31:0]      instr;
    logic [3:0]       cpu_state;
    logic [STG_W-1:0] instr_stg;
    logic             cede;
    logic             retire;
    logic             trap;
    logic [2:0]       trap_cause;

    modport master (
        output run, memctrl_ready, instr,
        input  cpu_state, instr_stg, cede, retire, trap, trap_cause
    );

    modport slave (
        input  run, memctrl_ready, instr,
        output cpu_state, instr_stg, cede, retire, trap, trap_cause
    );
endinterface

// File: rtl/fsm_seq.sv
// Multicycle control sequencer for the RV32I core: fetch/exec stage
// sequencing per opcode, bounded memory waits and trap reporting.
//
// state | meaning
// IDLE  | core stopped (run low), everything cleared
// FETCH | waiting for memctrl to deliver the next instruction
// EXEC  | stepping through the stages of the current instruction
// TRAP  | illegal encoding or memory timeout; held until run drops
module fsm_seq #(
    parameter int STG_W       = 3,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    fsm_seq_if.slave    bus
);

    typedef enum logic [3:0] {
        IDLE  = 4'd0,
        FETCH = 4'd1,
        EXEC  = 4'd2,
        TRAP  = 4'd3
    } state_t;

    localparam logic [2:0] C_NONE      = 3'd0;
    localparam logic [2:0] C_ILL_OP    = 3'd1;
    localparam logic [2:0] C_ILL_F3    = 3'd2;
    localparam logic [2:0] C_FETCH_TMO = 3'd3;
    localparam logic [2:0] C_DATA_TMO  = 3'd4;

    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_CEDE   = 7'b0000000;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [STG_W-1:0] S0 = STG_W'(0);
    localparam logic [STG_W-1:0] S1 = STG_W'(1);
    localparam logic [STG_W-1:0] S2 = STG_W'(2);

    // Counter wide enough to hold MEM_TIMEOUT; with the timeout disabled it
    // simply wraps and is never compared.
    localparam int               CNT_W   = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TMO_CNT = CNT_W'(MEM_TIMEOUT);
    localparam bit               TMO_EN  = (MEM_TIMEOUT != 0);

    state_t           state_q, state_d;
    logic [STG_W-1:0] stg_q, stg_d;
    logic [2:0]       cause_q, cause_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             trap_q;

    logic [6:0]       opcode;
    logic [2:0]       funct3;
    logic             tmo_hit;
    logic             done;
    logic             wait_c;
    logic [2:0]       wait_cause;
    logic             trap_req;
    logic [2:0]       trap_cause_c;
    logic             retire_c;
    logic             unused_instr_bits;

    assign opcode            = bus.instr[6:0];
    assign funct3            = bus.instr[14:12];
    assign unused_instr_bits = ^{bus.instr[31:15], bus.instr[11:7]};
    assign tmo_hit           = TMO_EN && (cnt_q == TMO_CNT);

    // State, stage, cause and wait-counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            stg_q   <= '0;
            cause_q <= C_NONE;
            cnt_q   <= '0;
            trap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            stg_q   <= stg_d;
            cause_q <= cause_d;
            cnt_q   <= cnt_d;
            trap_q  <= (state_d == TRAP);
        end
    end

    // Next-state, stage sequencing, wait/timeout handling and retire strobe.
    always_comb begin
        state_d      = state_q;
        stg_d        = stg_q;
        cause_d      = cause_q;
        cnt_d        = '0;
        done         = 1'b0;
        wait_c       = 1'b0;
        wait_cause   = C_DATA_TMO;
        trap_req     = 1'b0;
        trap_cause_c = C_NONE;
        retire_c     = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.run) begin
                    state_d = FETCH;
                    stg_d   = S0;
                end
            end
            FETCH: begin
                if (bus.memctrl_ready) begin
                    state_d = EXEC;
                    stg_d   = S0;
                end else begin
                    wait_c     = 1'b1;
                    wait_cause = C_FETCH_TMO;
                end
            end
            EXEC: begin
                case (opcode)
                    OP_JALR: begin
                        if (stg_q >= S2) done = 1'b1;
                        else             stg_d = stg_q + S1;
                    end
                    OP_BRANCH: begin
                        if (stg_q >= S1) done = 1'b1;
                        else             stg_d = S1;
                    end
                    OP_LOAD: begin
                        case (funct3)
                            3'b000, 3'b001: begin
                                if (stg_q == S0)               stg_d = S1;
                                else if (stg_q == S1) begin
                                    if (bus.memctrl_ready)     stg_d = S2;
                                    else                       wait_c = 1'b1;
                                end else                       done = 1'b1;
                            end
                            3'b100, 3'b101, 3'b010: begin
                                if (stg_q == S0)               stg_d = S1;
                                else if (bus.memctrl_ready)    done = 1'b1;
                                else                           wait_c = 1'b1;
                            end
                            default: begin
                                trap_req     = 1'b1;
                                trap_cause_c = C_ILL_F3;
                            end
                        endcase
                    end
                    OP_STORE: begin
                        case (funct3)
                            3'b000, 3'b001, 3'b010: begin
                                if (stg_q == S0)               stg_d = S1;
                                else if (stg_q == S1)          stg_d = S2;
                                else if (bus.memctrl_ready)    done = 1'b1;
                                else                           wait_c = 1'b1;
                            end
                            default: begin
                                trap_req     = 1'b1;
                                trap_cause_c = C_ILL_F3;
                            end
                        endcase
                    end
                    OP_CEDE: begin
                        // Hold state and stage until run drops.
                    end
                    OP_LUI, OP_AUIPC, OP_JAL, OP_OPIMM, OP_OP, OP_FENCE, OP_SYSTEM: begin
                        done = 1'b1;
                    end
                    default: begin
                        trap_req     = 1'b1;
                        trap_cause_c = C_ILL_OP;
                    end
                endcase
            end
            TRAP: begin
                // Only run=0 leaves TRAP.
            end
            default: begin
                state_d = IDLE;
                stg_d   = S0;
                cause_d = C_NONE;
            end
        endcase

        // Counter only runs while a wait sees ready low; every other path
        // leaves it at zero, which also clears it on wait entry.
        if (wait_c) begin
            if (tmo_hit) begin
                trap_req     = 1'b1;
                trap_cause_c = wait_cause;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        if (done) begin
            retire_c = 1'b1;
            state_d  = FETCH;
            stg_d    = S0;
        end

        if (trap_req) begin
            state_d = TRAP;
            stg_d   = S0;
            cause_d = trap_cause_c;
        end

        if (!bus.run) begin
            state_d  = IDLE;
            stg_d    = S0;
            cause_d  = C_NONE;
            cnt_d    = '0;
            retire_c = 1'b0;
        end
    end

    assign bus.cpu_state  = state_q;
    assign bus.instr_stg  = stg_q;
    assign bus.trap       = trap_q;
    assign bus.trap_cause = cause_q;
    assign bus.retire     = retire_c;
    assign bus.cede       = (state_q == EXEC) && (opcode == OP_CEDE);

endmodule
